// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 distribution demultiplexer.
package demux_pkg;

    localparam int WIDTH_PADRAO = 4;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_A = 2'd0;
    localparam sel_t SEL_B = 2'd1;
    localparam sel_t SEL_C = 2'd2;
    localparam sel_t SEL_D = 2'd3;

endpackage

// File: rtl/slot_saida.sv
// One output channel: a single-entry holding register with a valid/ready handshake.
module slot_saida #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             carrega,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    // A load wins over a drain so a word can replace the leaving one without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (carrega) begin
            dout  <= din;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_distribuidor.sv
// Registered 1-to-4 demultiplexer: routes each accepted input word to channel A..D,
// chosen by the manual select keys or by an internal round-robin counter.
module demux_distribuidor
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_PADRAO
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] inX,
    input  logic             inValid,
    output logic             inReady,
    input  logic             chave0,
    input  logic             chave1,
    input  logic             modoAuto,
    output logic [WIDTH-1:0] outA,
    output logic [WIDTH-1:0] outB,
    output logic [WIDTH-1:0] outC,
    output logic [WIDTH-1:0] outD,
    output logic             validA,
    output logic             validB,
    output logic             validC,
    output logic             validD,
    input  logic             readyA,
    input  logic             readyB,
    input  logic             readyC,
    input  logic             readyD,
    output logic [1:0]       alvo
);

    sel_t       rr;
    sel_t       alvoSel;
    logic [3:0] validVec;
    logic [3:0] readyVec;
    logic [3:0] carrega;
    logic       aceite;

    assign readyVec = {readyD, readyC, readyB, readyA};
    assign alvoSel  = modoAuto ? rr : sel_t'({chave1, chave0});
    assign alvo     = alvoSel;
    assign inReady  = rst_n & (~validVec[alvoSel] | readyVec[alvoSel]);
    assign aceite   = inValid & inReady;

    assign validA = validVec[0];
    assign validB = validVec[1];
    assign validC = validVec[2];
    assign validD = validVec[3];

    // One-hot load strobe: only the current target channel may take the accepted word.
    always_comb begin
        carrega    = '0;
        carrega[0] = aceite & (alvoSel == SEL_A);
        carrega[1] = aceite & (alvoSel == SEL_B);
        carrega[2] = aceite & (alvoSel == SEL_C);
        carrega[3] = aceite & (alvoSel == SEL_D);
    end

    // Round-robin pointer advances only on words accepted in auto mode, so it survives mode switches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= SEL_A;
        end else if (aceite && modoAuto) begin
            rr <= rr + 2'd1;
        end
    end

    slot_saida #(.WIDTH(WIDTH)) slotA (
        .clk(clk), .rst_n(rst_n), .carrega(carrega[0]), .din(inX),
        .ready(readyA), .dout(outA), .valid(validVec[0])
    );

    slot_saida #(.WIDTH(WIDTH)) slotB (
        .clk(clk), .rst_n(rst_n), .carrega(carrega[1]), .din(inX),
        .ready(readyB), .dout(outB), .valid(validVec[1])
    );

    slot_saida #(.WIDTH(WIDTH)) slotC (
        .clk(clk), .rst_n(rst_n), .carrega(carrega[2]), .din(inX),
        .ready(readyC), .dout(outC), .valid(validVec[2])
    );

    slot_saida #(.WIDTH(WIDTH)) slotD (
        .clk(clk), .rst_n(rst_n), .carrega(carrega[3]), .din(inX),
        .ready(readyD), .dout(outD), .valid(validVec[3])
    );

endmodule

// File: tb/tb_demux_distribuidor.sv
// Self-checking bench for demux_distribuidor: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of four single-entry channels.
module tb_demux_distribuidor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] inX;
    logic       inValid;
    logic       inReady;
    logic       chave0;
    logic       chave1;
    logic       modoAuto;
    logic [3:0] outA, outB, outC, outD;
    logic       validA, validB, validC, validD;
    logic [3:0] rdyVec;
    logic [1:0] alvo;

    logic [3:0] dutOut[4];
    logic       dutValid[4];

    logic [3:0] mData[4];
    logic       mValid[4];
    logic [1:0] mRr;

    int errors = 0;
    int checks = 0;

    string chNames[4] = '{"A", "B", "C", "D"};

    demux_distribuidor #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .inX(inX), .inValid(inValid), .inReady(inReady),
        .chave0(chave0), .chave1(chave1), .modoAuto(modoAuto),
        .outA(outA), .outB(outB), .outC(outC), .outD(outD),
        .validA(validA), .validB(validB), .validC(validC), .validD(validD),
        .readyA(rdyVec[0]), .readyB(rdyVec[1]), .readyC(rdyVec[2]), .readyD(rdyVec[3]),
        .alvo(alvo)
    );

    always #5 clk = ~clk;

    assign dutOut[0] = outA;
    assign dutOut[1] = outB;
    assign dutOut[2] = outC;
    assign dutOut[3] = outD;
    assign dutValid[0] = validA;
    assign dutValid[1] = validB;
    assign dutValid[2] = validC;
    assign dutValid[3] = validD;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] modelAlvo();
        return modoAuto ? mRr : {chave1, chave0};
    endfunction

    function automatic logic modelReady();
        logic [1:0] t;
        t = modelAlvo();
        return rst_n & (!mValid[t] | rdyVec[t]);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            mData[i]  = '0;
            mValid[i] = 1'b0;
        end
        mRr = 2'd0;
    endtask

    task automatic checkOutput();
        checkVal("alvo", {30'd0, alvo}, {30'd0, modelAlvo()});
        checkVal("inReady", {31'd0, inReady}, {31'd0, modelReady()});
        for (int i = 0; i < 4; i++) begin
            checkVal({"out", chNames[i]}, {28'd0, dutOut[i]}, {28'd0, mData[i]});
            checkVal({"valid", chNames[i]}, {31'd0, dutValid[i]}, {31'd0, mValid[i]});
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] x, input logic auto,
                                 input logic [1:0] sel, input logic [3:0] rdy);
        inValid  = v;
        inX      = x;
        modoAuto = auto;
        {chave1, chave0} = sel;
        rdyVec   = rdy;
    endtask

    // Called just after a falling edge with inputs applied; checks, then advances one clock.
    task automatic stepCycle();
        logic [1:0] t;
        logic       acc;
        logic [3:0] x;
        logic [3:0] rdy;
        logic       auto;
        #1;
        checkOutput();
        t    = modelAlvo();
        acc  = inValid & modelReady();
        x    = inX;
        rdy  = rdyVec;
        auto = modoAuto;
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (acc && t == 2'(i)) begin
                    mData[i]  = x;
                    mValid[i] = 1'b1;
                end else if (mValid[i] && rdy[i]) begin
                    mValid[i] = 1'b0;
                end
            end
            if (acc && auto) mRr = mRr + 2'd1;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 4'h0, 1'b1, 2'd0, 4'h0);
        modelReset();
        @(negedge clk);
        #1;
        checkOutput();
        checkVal("resetInReady", {31'd0, inReady}, 32'd0);
        checkVal("resetValidA", {31'd0, validA}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Manual routing to C, then backpressure until readyC.
        applyStimulus(1'b1, 4'h9, 1'b0, 2'd2, 4'h0);
        stepCycle();
        checkVal("manualOutC", {28'd0, outC}, 32'h9);
        checkVal("manualValidC", {31'd0, validC}, 32'd1);
        checkVal("manualValidA", {31'd0, validA}, 32'd0);
        applyStimulus(1'b1, 4'hA, 1'b0, 2'd2, 4'h0);
        #1;
        checkVal("holdCReady", {31'd0, inReady}, 32'd0);
        stepCycle();
        applyStimulus(1'b1, 4'hA, 1'b0, 2'd2, 4'b0100);
        #1;
        checkVal("releaseCReady", {31'd0, inReady}, 32'd1);
        stepCycle();
        checkVal("manualOutC2", {28'd0, outC}, 32'hA);
        applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 4'hF);
        stepCycle();

        // Auto round-robin with wrap.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 4'(i), 1'b1, 2'd0, 4'hF);
            stepCycle();
        end
        checkVal("rrOutA", {28'd0, outA}, 32'h5);
        checkVal("rrOutB", {28'd0, outB}, 32'h2);
        checkVal("rrOutC", {28'd0, outC}, 32'h3);
        checkVal("rrOutD", {28'd0, outD}, 32'h4);
        checkVal("rrWrapAlvo", {30'd0, alvo}, 32'd1);

        // Simultaneous drain and load on B.
        applyStimulus(1'b1, 4'h7, 1'b0, 2'd1, 4'h0);
        stepCycle();
        applyStimulus(1'b1, 4'hE, 1'b0, 2'd1, 4'b0010);
        #1;
        checkVal("drainLoadReady", {31'd0, inReady}, 32'd1);
        stepCycle();
        checkVal("drainLoadOutB", {28'd0, outB}, 32'hE);
        checkVal("drainLoadValidB", {31'd0, validB}, 32'd1);
        applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 4'hF);
        stepCycle();

        // Backpressure on A, then retarget to empty D.
        applyStimulus(1'b1, 4'h6, 1'b0, 2'd0, 4'h0);
        stepCycle();
        applyStimulus(1'b1, 4'h3, 1'b0, 2'd0, 4'h0);
        stepCycle();
        applyStimulus(1'b1, 4'h3, 1'b0, 2'd3, 4'h0);
        stepCycle();
        checkVal("retargetOutD", {28'd0, outD}, 32'h3);
        checkVal("retargetValidD", {31'd0, validD}, 32'd1);
        checkVal("retargetOutA", {28'd0, outA}, 32'h6);
        checkVal("retargetValidA", {31'd0, validA}, 32'd1);
        applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 4'hF);
        stepCycle();

        // Reset mid-stream with A holding a word.
        applyStimulus(1'b1, 4'h5, 1'b0, 2'd0, 4'h0);
        stepCycle();
        checkVal("preResetOutA", {28'd0, outA}, 32'h5);
        applyStimulus(1'b0, 4'h0, 1'b1, 2'd0, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        checkVal("midResetValidA", {31'd0, validA}, 32'd0);
        checkVal("midResetOutA", {28'd0, outA}, 32'h0);
        checkVal("midResetInReady", {31'd0, inReady}, 32'd0);
        checkVal("midResetAlvo", {30'd0, alvo}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mode switch: rr must survive the manual phase.
        applyStimulus(1'b1, 4'h1, 1'b1, 2'd0, 4'hF);
        stepCycle();
        checkVal("postResetOutA", {28'd0, outA}, 32'h1);
        applyStimulus(1'b1, 4'h2, 1'b1, 2'd0, 4'hF);
        stepCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'(8 + i), 1'b0, 2'd3, 4'hF);
            stepCycle();
        end
        applyStimulus(1'b1, 4'hC, 1'b1, 2'd0, 4'h0);
        stepCycle();
        checkVal("modeSwitchOutC", {28'd0, outC}, 32'hC);
        checkVal("modeSwitchValidC", {31'd0, validC}, 32'd1);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
                          2'($urandom), 4'($urandom));
            stepCycle();
        end

        applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 4'hF);
        stepCycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
